// File: rtl/mem_bridge.sv
// mem_bridge: CPU load/store handshake to word-wide tri-state RAM bus.
// Sub-word loads are extracted and extended; sub-word stores use read-modify-write.
// Ports:
//   clk, rst              clock, async active-high reset
//   req_valid/req_ready   request handshake
//   req_we/size/unsigned  access kind
//   req_addr/req_wdata    byte address, right-aligned store data
//   rsp_valid/rdata/err   one-cycle response
//   mem_we/addr/data      RAM bus; mem_data driven only while mem_we=1
module mem_bridge #(
  parameter int RAM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  inout  wire  [31:0] mem_data
);

  localparam logic [32:0] LP_BYTES = 33'(RAM_WORDS) << 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RMW_RD,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        w_err;
  logic        w_accept;
  logic        w_bus;

  function automatic logic [31:0] f_load(
    input logic [31:0] w,
    input logic [1:0]  a,
    input logic [1:0]  sz,
    input logic        u
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    unique case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    unique case (sz)
      2'b00:   r = {{24{b[7] & ~u}}, b};
      2'b01:   r = {{16{h[15] & ~u}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] f_merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [1:0]  a,
    input logic [1:0]  sz
  );
    logic [31:0] r;
    r = old;
    if (sz == 2'b00) begin
      unique case (a)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (sz == 2'b01) begin
      if (a[1]) r[31:16] = d[15:0];
      else      r[15:0]  = d[15:0];
    end else begin
      r = d;
    end
    return r;
  endfunction

  always_comb begin
    w_err = (req_size == 2'b11)
          | ((req_size == 2'b01) & req_addr[0])
          | ((req_size == 2'b10) & (|req_addr[1:0]))
          | ({1'b0, req_addr} >= LP_BYTES);
    w_accept = (r_state == S_IDLE) & req_valid;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_err)                 w_next = S_RESP;
          else if (!req_we)          w_next = S_READ;
          else if (req_size == 2'b10) w_next = S_WRITE;
          else                       w_next = S_RMW_RD;
        end
      end
      S_READ:   w_next = S_RESP;
      S_RMW_RD: w_next = S_WRITE;
      S_WRITE:  w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Bus outputs decode only from registered state, so they never glitch.
  always_comb begin
    w_bus     = (r_state == S_READ) | (r_state == S_RMW_RD) |
                (r_state == S_WRITE);
    req_ready = (r_state == S_IDLE);
    rsp_valid = (r_state == S_RESP);
    mem_we    = (r_state == S_WRITE);
    mem_addr  = w_bus ? {r_addr[31:2], 2'b00} : 32'h0;
  end

  assign mem_data  = mem_we ? r_wdata : 32'hz;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // rdata is cleared on accept so stores and errors respond with 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_size  <= 2'b00;
      r_uns   <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_rdata <= 32'h0;
        r_err   <= w_err;
      end
      if (r_state == S_READ)
        r_rdata <= f_load(mem_data, r_addr[1:0], r_size, r_uns);
      if (r_state == S_RMW_RD)
        r_wdata <= f_merge(mem_data, r_wdata, r_addr[1:0], r_size);
    end
  end

endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed and random load/store traffic against a word-array model.
// Ports: none (top-level bench).
module tb_mem_bridge;
  localparam int RW = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  wire  [31:0] mem_data;

  logic [31:0] ram [RW];
  logic [31:0] model_mem [RW];
  logic        ram_init;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic        active = 1'b0;
  int          t_c0 = 0;
  int          t_lat = 1;
  logic        t_err = 1'b0;
  logic        t_store = 1'b0;
  logic [31:0] t_addr = 32'h0;
  logic [31:0] t_rdata = 32'h0;
  logic [31:0] t_wword = 32'h0;
  logic [31:0] got_rdata = 32'h0;
  logic        got_err = 1'b0;

  mem_bridge #(.RAM_WORDS(RW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  assign mem_data = mem_we ? 32'hz : ram[mem_addr[11:2]];

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < RW; i++) ram[i] <= init_val(i);
    end else if (mem_we) begin
      ram[mem_addr[11:2]] <= mem_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
           (sz == 2'd2 && a % 4 != 0) || (64'(a) >= 64'(4 * RW));
  endfunction

  function automatic logic [31:0] m_mask(input logic [1:0] sz);
    return (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w,
      input logic [31:0] a, input logic [1:0] sz, input logic u);
    logic [31:0] mk;
    logic [31:0] v;
    int sh;
    mk = m_mask(sz);
    sh = 8 * int'(a % 4);
    v = (w >> sh) & mk;
    if (sz != 2'd2 && !u && ((v & ((mk + 1) >> 1)) != 0)) v = v | ~mk;
    return v;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w,
      input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mk;
    int sh;
    mk = m_mask(sz);
    sh = 8 * int'(a % 4);
    return (w & ~(mk << sh)) | ((d & mk) << sh);
  endfunction

  // Expected outputs derived from cycle offset k since the request cycle.
  always @(negedge clk) begin
    int k;
    logic busy;
    logic bus;
    logic wr;
    k = active ? cyc - t_c0 : -1;
    busy = active && k >= 1 && k <= t_lat;
    bus = active && !t_err && k >= 1 && k < t_lat;
    wr = active && t_store && !t_err && k == t_lat - 1;
    chk("req_ready", 32'(req_ready), 32'(!busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(active && k == t_lat));
    chk("mem_we", 32'(mem_we), 32'(wr));
    chk("mem_addr", mem_addr, bus ? {t_addr[31:2], 2'b00} : 32'h0);
    if (wr) chk("mem_data", mem_data, t_wword);
    if (active && k == t_lat) begin
      chk("rsp_err", 32'(rsp_err), 32'(t_err));
      chk("rsp_rdata", rsp_rdata, t_rdata);
      got_rdata = rsp_rdata;
      got_err = rsp_err;
    end
  end

  task automatic drive(input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    req_we = we;
    req_size = sz;
    req_unsigned = u;
    req_addr = a;
    req_wdata = d;
    req_valid = 1'b1;
  endtask

  // Called just after a rising edge with the bridge idle; returns likewise.
  task automatic do_txn(input logic we, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
    int idx;
    idx = int'(a[11:2]);
    t_err = m_err(sz, a);
    t_store = we;
    t_addr = a;
    t_lat = t_err ? 1 : (!we ? 2 : (sz == 2'd2 ? 2 : 3));
    t_rdata = 32'h0;
    t_wword = 32'h0;
    if (!t_err && !we) t_rdata = m_load(model_mem[idx], a, sz, u);
    if (!t_err && we) begin
      t_wword = m_store(model_mem[idx], a, sz, d);
      model_mem[idx] = t_wword;
    end
    drive(we, sz, u, a, d);
    t_c0 = cyc;
    active = 1'b1;
    @(posedge clk);
    #1;
    repeat (t_lat) begin
      drive($urandom_range(0, 1) == 1, 2'($urandom), 1'($urandom),
            $urandom, $urandom);
      req_valid = 1'($urandom);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  initial begin
    int mism;
    rst = 1'b1;
    ram_init = 1'b1;
    req_valid = 1'b0;
    req_we = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    for (int i = 0; i < RW; i++) model_mem[i] = init_val(i);
    repeat (2) @(posedge clk);
    #1;
    ram_init = 1'b0;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    chk("pin_model_b", m_load(32'h1122AA44, 32'h21, 2'd0, 1'b0), 32'hFFFFFFAA);
    chk("pin_model_m", m_store(32'h1122AA44, 32'h22, 2'd1, 32'h8001),
        32'h8001AA44);

    do_txn(1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    chk("st_word_err", 32'(got_err), 32'd0);
    do_txn(0, 2'd2, 0, 32'h10, 32'h0);
    chk("ld_word", got_rdata, 32'hDEADBEEF);

    do_txn(1, 2'd2, 0, 32'h20, 32'h11223344);
    do_txn(1, 2'd0, 0, 32'h21, 32'h000000AA);
    do_txn(0, 2'd0, 0, 32'h21, 32'h0);
    chk("ld_byte_s", got_rdata, 32'hFFFFFFAA);
    do_txn(0, 2'd0, 1, 32'h21, 32'h0);
    chk("ld_byte_u", got_rdata, 32'h000000AA);
    do_txn(0, 2'd2, 0, 32'h20, 32'h0);
    chk("rmw_byte_word", got_rdata, 32'h1122AA44);

    do_txn(1, 2'd1, 0, 32'h22, 32'h00008001);
    do_txn(0, 2'd1, 0, 32'h22, 32'h0);
    chk("ld_half_s", got_rdata, 32'hFFFF8001);
    do_txn(0, 2'd2, 0, 32'h20, 32'h0);
    chk("rmw_half_word", got_rdata, 32'h8001AA44);

    do_txn(1, 2'd1, 0, 32'h23, 32'h1234);
    chk("err_half", 32'(got_err), 32'd1);
    do_txn(0, 2'd2, 0, 32'h06, 32'h0);
    chk("err_word", 32'(got_err), 32'd1);
    chk("err_rdata", got_rdata, 32'h0);
    do_txn(1, 2'd3, 0, 32'h20, 32'hFFFFFFFF);
    chk("err_size", 32'(got_err), 32'd1);
    do_txn(1, 2'd2, 0, 32'h1000, 32'hCAFEF00D);
    chk("err_range", 32'(got_err), 32'd1);
    chk("err_mem_intact", ram[8], 32'h8001AA44);

    do_txn(1, 2'd2, 0, 32'h30, 32'h12345678);
    drive(1, 2'd2, 0, 32'h30, 32'h55555555);
    t_err = 1'b0;
    t_store = 1'b1;
    t_addr = 32'h30;
    t_lat = 2;
    t_rdata = 32'h0;
    t_wword = 32'h55555555;
    t_c0 = cyc;
    active = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort_we_before", 32'(mem_we), 32'd1);
    #1;
    rst = 1'b1;
    active = 1'b0;
    #1;
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_rsp", 32'(rsp_valid), 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_ram", ram[12], 32'h12345678);
    do_txn(0, 2'd2, 0, 32'h30, 32'h0);
    chk("abort_reload", got_rdata, 32'h12345678);

    for (int n = 0; n < 250; n++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      sz = 2'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 32'h10FF));
      if ($urandom_range(0, 3) != 0)
        a = a & ~((sz == 2'd2) ? 32'h3 : (sz == 2'd1) ? 32'h1 : 32'h0);
      do_txn($urandom_range(0, 1) == 1, sz, 1'($urandom), a, $urandom);
    end

    mism = 0;
    for (int i = 0; i < RW; i++)
      if (ram[i] !== model_mem[i]) mism++;
    chk("ram_final_mism", 32'(mism), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
# mem_bridge

Load/store bridge between a CPU-side request/response handshake and the word-wide tri-state memory bus (`mem_we`, `mem_addr`, `mem_data`) of the on-chip data RAM. Loads of byte, halfword and word come back extracted and sign/zero-extended. Word stores go straight through. Byte and halfword stores are done as read-modify-write, because the RAM only writes whole words. Misaligned or out-of-range accesses return an error without touching memory.

## Interface
- `RAM_WORDS`, default 1024: RAM depth in 32-bit words; valid byte addresses are 0 .. 4*RAM_WORDS-1.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: bridge can accept; equals (state == IDLE).
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 halfword, 10 word; 11 is an error.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1: one-cycle response pulse; no backpressure.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `rsp_err` out 1: valid with `rsp_valid`; misaligned, out of range, or bad size.
- `mem_we` out 1: RAM write enable.
- `mem_addr` out 32: word-aligned byte address, {addr[31:2], 2'b00}.
- `mem_data` inout 32: driven by the bridge only while `mem_we`=1, otherwise high-Z. The RAM drives it combinationally while `mem_we`=0.

## Operation
- FSM states: IDLE, READ, RMW_RD, WRITE, RESP.
- **IDLE:**
  - On `req_valid` && `req_ready`, latch we/size/unsigned/addr/wdata.
  - Error check: size==11; half with addr[0]!=0; word with addr[1:0]!=0; addr >= 4*RAM_WORDS. On error, go to RESP with err=1.
  - Load goes to READ. Word store goes to WRITE. Byte/half store goes to RMW_RD.
- **READ:**
  - Outputs: `mem_we`=0, `mem_addr`=latched word address.
  - Sample `mem_data` at the clock edge.
  - Extract the lane and extend per size/unsigned into `rsp_rdata`, then go to RESP.
- **RMW_RD:**
  - Same bus drive as READ; sample the old word.
  - Merge new data into the selected lane; go to WRITE.
- **WRITE:**
  - Outputs: `mem_we`=1, `mem_addr`=word address, `mem_data`=merged word (or `req_wdata` for word stores).
  - The RAM writes on this cycle's closing edge; go to RESP.
- **RESP:** `rsp_valid`=1 for exactly one cycle, then IDLE. `req_ready`=0 during RESP.
- **Lane mapping (little-endian):**
  - Byte k = addr[1:0] occupies bits [8k+7:8k].
  - Half h = addr[1] occupies bits [16h+15:16h].
- **Extension:** sign-extend takes the top bit of the selected lane. Word loads ignore `req_unsigned`.
- **Idle bus:** `mem_addr`=0, `mem_we`=0, `mem_data`=Z in IDLE and RESP.
- **Outstanding requests:** only one at a time; `req_*` inputs are ignored outside IDLE.

## Timing
- **Reset values:**
  - state=IDLE, so `req_ready`=1.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_data`=Z.
- **Latency** (accept edge = cycle 0; RESP cycle given):
  - load: 2
  - word store: 2
  - byte/half store: 3
  - error: 1
- **Throughput:** the next accept is possible on the cycle after RESP. Back-to-back loads therefore run every 3 cycles.
- **Bus outputs:** `mem_we`/`mem_addr` are decoded from the registered state and latched address, so they are glitch-free within a cycle.
- **Bus turnaround:** the bridge releases `mem_data` in the same cycle `mem_we` falls. The RAM's combinational drive begins only when `mem_we`=0, so no contention.
- **Reset mid-operation:** `rst` asserted in any state forces IDLE immediately. If asserted during WRITE before the edge, `mem_we` drops and the write does not occur. No response is issued for the aborted request.
- **`rsp_rdata` hold:** holds its last value outside RESP; consumers qualify it with `rsp_valid`.

## Test plan
- **Word round-trip:** store word 0xDEADBEEF @0x10 → RESP 2 cycles later, err=0. Then load word @0x10 → `rsp_rdata`=0xDEADBEEF.
- **Byte RMW:**
  - Setup: word @0x20 = 0x11223344.
  - Store byte 0xAA @0x21 → 3-cycle latency; word becomes 0x1122AA44.
  - Load byte @0x21 signed → 0xFFFFFFAA; unsigned → 0x000000AA.
- **Half RMW:** store half 0x8001 @0x22 over 0x1122AA44 → word 0x8001AA44. Load half @0x22 signed → 0xFFFF8001.
- **Errors:**
  - half @0x23, word @0x06, size=11, and word @0x1000 (RAM_WORDS=1024) → RESP 1 cycle later, err=1, rdata=0.
  - `mem_we` never asserted; memory unchanged.
- **Reset abort:** pulse `rst` during the WRITE cycle of a store of 0x55555555 @0x30 → no write (reload still returns the old value), no `rsp_valid`, `req_ready`=1 immediately.
